pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC for the single-issue multicycle NPC core and issues one instruction-fetch request at a time.
- After execute resolves the instruction, it consumes the branch-unit result (ben) plus jump indications to select the next PC, then fetches again.
- Sits directly downstream of the branch unit and upstream of the fetch interface.
- Also provides the link address for jal/jalr writeback, a retired-instruction counter, and a sticky misaligned-target halt.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- if_valid  output  1  fetch request valid.
- if_ready  input  1  fetch interface accepts the request.
- if_pc  output  32  fetch address; always equals the current PC register.
- ex_valid  input  1  execute has resolved the current instruction (single-cycle pulse or level).
- ex_ben  input  1  branch-taken from the branch unit, already gated by the branch opcode.
- ex_jal  input  1  current instruction is jal.
- ex_jalr  input  1  current instruction is jalr.
- ex_imm  input  32  sign-extended immediate.
- ex_rs1  input  32  rs1 value (jalr base).
- link_pc  output  32  pc+4, combinational from the PC register.
- redirect  output  1  one-cycle pulse when a non-sequential PC is committed.
- halted  output  1  sticky misaligned-target halt.
- bad_addr  output  32  offending target when halted.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, including mid-fetch or mid-exec):
  - pc=RESET_PC, state=BOOT.
  - if_valid=0, redirect=0, halted=0, bad_addr=0, instret=0.
- States: BOOT, FETCH, EXEC, HALT.
- BOOT: if_valid=0; unconditionally moves to FETCH on the next edge, so if_valid first rises one cycle after reset release.
- FETCH:
  - if_valid=1, with if_pc held stable until the handshake.
  - if_valid & if_ready on an edge -> EXEC; if_valid is 0 from the next cycle.
  - if_ready low -> stay in FETCH with no change to any output.
- EXEC:
  - if_valid=0; wait for ex_valid.
  - ex_valid seen in any state other than EXEC is ignored: no counter or PC change.
- Next-PC selection on ex_valid in EXEC, priority order, all arithmetic modulo 2^32 with carry discarded:
  1. ex_jalr: target=(ex_rs1+ex_imm) & 32'hFFFF_FFFE.
  2. ex_jal: target=pc+ex_imm.
  3. ex_ben: target=pc+ex_imm.
  4. otherwise: target=pc+4.
  - Simultaneous flags resolve by this priority; jalr beats jal beats ben.
- Commit on that edge:
  - If target[1:0]==2'b00: pc<=target, instret<=instret+1, state<=FETCH. redirect=1 for exactly the following cycle if case 1, 2 or 3 was selected; otherwise 0.
  - If target[1:0]!=2'b00: pc unchanged, instret unchanged, bad_addr<=target, halted<=1, state<=HALT, redirect stays 0.
- HALT: if_valid=0; all registers frozen; only reset exits.
- instret wraps from all-ones to 0 silently.
- link_pc=pc+4, modulo 2^32 (pc=32'hFFFF_FFFC gives link_pc=0).
- Throughput: each instruction takes at least 2 cycles (FETCH accept + EXEC resolve). Nothing is in flight across a redirect, so no flush is needed.

Test Plan:
1. Reset release, if_ready=1, ex_valid asserted each EXEC cycle, no flags -> if_valid rises 1 cycle after reset; if_pc sequence 0x80000000, 0x80000004, 0x80000008; instret=3; redirect never 1.
2. pc=0x80000010, ex_ben=1, ex_imm=0xFFFFFFF8 -> next if_pc=0x80000008; redirect pulses exactly 1 cycle; link_pc before commit=0x80000014.
3. ex_jalr=1, ex_jal=1, ex_ben=1 together; ex_rs1=0x80001001, ex_imm=0x4 -> target 0x80001004 (bit0 cleared, jalr priority); no halt.
4. ex_jal=1, ex_imm=0x6 at pc=0x80000000 -> halted=1, bad_addr=0x80000006, pc stays 0x80000000, if_valid stays 0, instret unchanged.
5. FETCH with if_ready low for 5 cycles -> if_valid=1 and if_pc constant throughout; EXEC entered only on the cycle after if_ready=1. ex_valid pulsed during FETCH is ignored.
6. Assert rst_n=0 mid-EXEC -> if_valid=0 and instret=0 immediately (same cycle, asynchronous); after release if_pc=RESET_PC and BOOT->FETCH repeats.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Owns the architectural PC of the single-issue multicycle core. Issues one
//   fetch request at a time, waits for execute to resolve the instruction,
//   then selects the next PC from the jalr/jal/branch indications. Also
//   provides the jal/jalr link address, a retired-instruction counter and a
//   sticky halt on a misaligned control-transfer target.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   if_valid / if_ready  fetch request handshake
//   if_pc                fetch address (current PC)
//   ex_valid             execute has resolved the current instruction
//   ex_ben/jal/jalr      control-transfer indications (jalr > jal > ben)
//   ex_imm, ex_rs1       immediate and jalr base
//   link_pc              pc+4 for link writeback
//   redirect             one-cycle pulse after a non-sequential commit
//   halted, bad_addr     sticky misaligned-target halt and offending target
//   instret              retired-instruction count
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_pc,
  input  logic             ex_valid,
  input  logic             ex_ben,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  output logic [31:0]      link_pc,
  output logic             redirect,
  output logic             halted,
  output logic [31:0]      bad_addr,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      bad_addr_q, bad_addr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             redirect_q, redirect_d;
  logic             halted_q, halted_d;
  logic [31:0]      target;
  logic             nonseq;

  // Next-PC candidate; only consumed when ex_valid is seen in EXEC.
  always_comb begin
    nonseq = 1'b1;
    if (ex_jalr) begin
      target = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    end else if (ex_jal || ex_ben) begin
      target = pc_q + ex_imm;
    end else begin
      target = pc_q + 32'd4;
      nonseq = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bad_addr_d = bad_addr_q;
    instret_d  = instret_q;
    halted_d   = halted_q;
    redirect_d = 1'b0;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: if (if_ready) state_d = EXEC;
      EXEC: begin
        if (ex_valid) begin
          if (target[1:0] == 2'b00) begin
            pc_d       = target;
            instret_d  = instret_q + CNT_W'(1);
            redirect_d = nonseq;
            state_d    = FETCH;
          end else begin
            // Misaligned target: freeze PC and count, record the target.
            bad_addr_d = target;
            halted_d   = 1'b1;
            state_d    = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      bad_addr_q <= 32'd0;
      instret_q  <= '0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bad_addr_q <= bad_addr_d;
      instret_q  <= instret_d;
      redirect_q <= redirect_d;
      halted_q   <= halted_d;
    end
  end

  assign if_valid = (state_q == FETCH);
  assign if_pc    = pc_q;
  assign link_pc  = pc_q + 32'd4;
  assign redirect = redirect_q;
  assign halted   = halted_q;
  assign bad_addr = bad_addr_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic        ex_valid = 1'b0;
  logic        ex_ben = 1'b0;
  logic        ex_jal = 1'b0;
  logic        ex_jalr = 1'b0;
  logic [31:0] ex_imm = 32'd0;
  logic [31:0] ex_rs1 = 32'd0;
  logic [31:0] link_pc;
  logic        redirect;
  logic        halted;
  logic [31:0] bad_addr;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;

  pc_fetch_ctrl #(.RESET_PC(32'h8000_0000), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .ex_valid(ex_valid), .ex_ben(ex_ben), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .link_pc(link_pc),
    .redirect(redirect), .halted(halted), .bad_addr(bad_addr), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reset, release on a falling edge; DUT is in BOOT afterwards.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; if_ready = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // From FETCH at a falling edge: accept fetch, resolve with given flags,
  // return at the falling edge after the commit edge.
  task automatic step(input logic jalr, input logic jal, input logic ben,
                      input logic [31:0] imm, input logic [31:0] rs1);
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    ex_valid = 1'b1; ex_jalr = jalr; ex_jal = jal; ex_ben = ben;
    ex_imm = imm; ex_rs1 = rs1;
    @(negedge clk);
    ex_valid = 1'b0; ex_jalr = 1'b0; ex_jal = 1'b0; ex_ben = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'h8000_0000) begin failures++; $display("FAIL rst_if_pc got=%h exp=80000000", if_pc); end
    checks++; if (redirect !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", redirect, halted); end
    checks++; if (bad_addr !== 32'd0) begin failures++; $display("FAIL rst_bad_addr got=%h exp=0", bad_addr); end
    checks++; if (instret !== 64'd0) begin failures++; $display("FAIL rst_instret got=%0d exp=0", instret); end
  endtask

  task automatic test_sequential();
    do_reset();
    if_ready = 1'b1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL boot_if_valid got=%b exp=0", if_valid); end
    if_ready = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin failures++; $display("FAIL seq_fetch0 got=%b/%h exp=1/80000000", if_valid, if_pc); end
    step(0, 0, 0, 32'h0, 32'h0);
    checks++; if (if_pc !== 32'h8000_0004 || redirect !== 1'b0) begin failures++; $display("FAIL seq_pc1 got=%h/%b exp=80000004/0", if_pc, redirect); end
    step(0, 0, 0, 32'h0, 32'h0);
    checks++; if (if_pc !== 32'h8000_0008 || redirect !== 1'b0) begin failures++; $display("FAIL seq_pc2 got=%h/%b exp=80000008/0", if_pc, redirect); end
    step(0, 0, 0, 32'h0, 32'h0);
    checks++; if (if_pc !== 32'h8000_000C || redirect !== 1'b0) begin failures++; $display("FAIL seq_pc3 got=%h/%b exp=8000000c/0", if_pc, redirect); end
    checks++; if (instret !== 64'd3) begin failures++; $display("FAIL seq_instret got=%0d exp=3", instret); end
  endtask

  task automatic test_branch();
    step(0, 0, 0, 32'h0, 32'h0);
    checks++; if (if_pc !== 32'h8000_0010) begin failures++; $display("FAIL br_pre_pc got=%h exp=80000010", if_pc); end
    checks++; if (link_pc !== 32'h8000_0014) begin failures++; $display("FAIL br_link got=%h exp=80000014", link_pc); end
    step(0, 0, 1, 32'hFFFF_FFF8, 32'h0);
    checks++; if (if_pc !== 32'h8000_0008) begin failures++; $display("FAIL br_target got=%h exp=80000008", if_pc); end
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL br_redirect got=%b exp=1", redirect); end
    checks++; if (instret !== 64'd5) begin failures++; $display("FAIL br_instret got=%0d exp=5", instret); end
    @(negedge clk);
    checks++; if (redirect !== 1'b0 || if_valid !== 1'b1) begin failures++; $display("FAIL br_pulse got=%b/%b exp=0/1", redirect, if_valid); end
  endtask

  task automatic test_jalr_priority();
    step(1, 1, 1, 32'h0000_0004, 32'h8000_1001);
    checks++; if (if_pc !== 32'h8000_1004) begin failures++; $display("FAIL jalr_target got=%h exp=80001004", if_pc); end
    checks++; if (halted !== 1'b0 || redirect !== 1'b1) begin failures++; $display("FAIL jalr_flags got=%b/%b exp=0/1", halted, redirect); end
    // jal beats ben: ben alone would use the same adder, so use jalr-off/jal-on with ben.
    step(0, 1, 1, 32'h0000_0100, 32'h0);
    checks++; if (if_pc !== 32'h8000_1104) begin failures++; $display("FAIL jal_target got=%h exp=80001104", if_pc); end
    step(1, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC);
    checks++; if (if_pc !== 32'hFFFF_FFFC || link_pc !== 32'h0) begin failures++; $display("FAIL link_wrap got=%h/%h exp=fffffffc/0", if_pc, link_pc); end
    checks++; if (instret !== 64'd8) begin failures++; $display("FAIL jalr_instret got=%0d exp=8", instret); end
  endtask

  task automatic test_misaligned();
    do_reset();
    @(negedge clk);
    step(0, 1, 0, 32'h0000_0006, 32'h0);
    checks++; if (halted !== 1'b1 || bad_addr !== 32'h8000_0006) begin failures++; $display("FAIL mis_halt got=%b/%h exp=1/80000006", halted, bad_addr); end
    checks++; if (if_pc !== 32'h8000_0000 || if_valid !== 1'b0) begin failures++; $display("FAIL mis_pc got=%h/%b exp=80000000/0", if_pc, if_valid); end
    checks++; if (instret !== 64'd0 || redirect !== 1'b0) begin failures++; $display("FAIL mis_cnt got=%0d/%b exp=0/0", instret, redirect); end
    if_ready = 1'b1; ex_valid = 1'b1;
    repeat (4) @(negedge clk);
    if_ready = 1'b0; ex_valid = 1'b0;
    checks++; if (halted !== 1'b1 || if_valid !== 1'b0 || if_pc !== 32'h8000_0000 || instret !== 64'd0) begin failures++; $display("FAIL mis_frozen got=%b/%b/%h/%0d exp=1/0/80000000/0", halted, if_valid, if_pc, instret); end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    ex_valid = 1'b1; ex_ben = 1'b1; ex_imm = 32'h40;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin failures++; $display("FAIL stall_%0d got=%b/%h exp=1/80000000", i, if_valid, if_pc); end
      @(negedge clk);
    end
    ex_valid = 1'b0; ex_ben = 1'b0;
    checks++; if (instret !== 64'd0 || if_pc !== 32'h8000_0000) begin failures++; $display("FAIL stall_ignore got=%0d/%h exp=0/80000000", instret, if_pc); end
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL stall_exec got=%b exp=0", if_valid); end
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    checks++; if (if_pc !== 32'h8000_0004 || instret !== 64'd1) begin failures++; $display("FAIL stall_commit got=%h/%0d exp=80000004/1", if_pc, instret); end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 32'h0, 32'h0);
    checks++; if (instret !== 64'd2) begin failures++; $display("FAIL ar_pre got=%0d exp=2", instret); end
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || instret !== 64'd0 || if_pc !== 32'h8000_0000) begin failures++; $display("FAIL ar_now got=%b/%0d/%h exp=0/0/80000000", if_valid, instret, if_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL ar_boot got=%b exp=0", if_valid); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000) begin failures++; $display("FAIL ar_fetch got=%b/%h exp=1/80000000", if_valid, if_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr_priority();
    test_misaligned();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
